// File: rtl/dcf77_frame_reader_if.sv
// Wishbone classic read-only link between the DCF77 frame reader (master) and
// the register slave that holds the eight frame bytes.
//   wb_cyc    : bus cycle, master -> slave
//   wb_stb    : strobe, master -> slave
//   wb_we     : write enable, master -> slave (always 0, reads only)
//   wb_ack    : acknowledge, slave -> master
//   wb_data_i : 8-bit read data, slave -> master
interface dcf77_frame_reader_if;
    logic       wb_cyc;
    logic       wb_stb;
    logic       wb_we;
    logic       wb_ack;
    logic [7:0] wb_data_i;

    modport master (
        output wb_cyc,
        output wb_stb,
        output wb_we,
        input  wb_ack,
        input  wb_data_i
    );

    modport slave (
        input  wb_cyc,
        input  wb_stb,
        input  wb_we,
        output wb_ack,
        output wb_data_i
    );
endinterface

// File: rtl/dcf77_frame_reader.sv
// DCF77 frame reader: on a start pulse, reads eight bytes over Wishbone from a
// register slave and assembles them into the 59-bit DCF77 frame.
//   clk, rst : clock and synchronous active-high reset
//   start    : single-cycle request to fetch one frame (ignored while busy)
//   busy     : a transaction is in progress
//   done     : one-cycle pulse, frame captured
//   err      : one-cycle pulse, transaction aborted on ack timeout
//   frame    : last successfully captured frame, bits [58:0]
//   frame_ok : plausibility flag, only when DCF77_READER_CHECK_EN is defined
//   wb       : Wishbone master modport
// Optional feature macro: DCF77_READER_CHECK_EN (adds frame_ok).
// ACK_TIMEOUT (2..255) is the number of stb-high cycles tolerated per byte.
module dcf77_frame_reader #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [58:0]                 frame,
`ifdef DCF77_READER_CHECK_EN
    output logic                        frame_ok,
`endif
    dcf77_frame_reader_if.master        wb
);

    typedef enum logic [1:0] {StIdle, StReq, StGap} state_e;

    localparam logic [7:0] TmoLast = 8'(ACK_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  tmo_q, tmo_d;
    // Only the low 51 bits survive seven 8-bit shifts, which drops byte 0 bits [7:3].
    logic [50:0] shadow_q, shadow_d;
    logic [58:0] frame_q, frame_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [58:0] frame_new;

    assign frame_new = {shadow_q, wb.wb_data_i};

`ifdef DCF77_READER_CHECK_EN
    logic frame_ok_q, frame_ok_d;

    function automatic logic plausible(input logic [58:0] f);
        return (f[0] == 1'b0) && (f[20] == 1'b1) && ((^f[28:21]) == 1'b0) &&
               ((^f[35:29]) == 1'b0) && ((^f[58:36]) == 1'b0);
    endfunction
`endif

    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        frame_d  = frame_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef DCF77_READER_CHECK_EN
        frame_ok_d = frame_ok_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    byte_d  = 3'd0;
                    tmo_d   = 8'd0;
                end
            end
            StReq: begin
                // An ack wins over a timeout reached in the same cycle.
                if (wb.wb_ack) begin
                    tmo_d = 8'd0;
                    if (byte_q == 3'd7) begin
                        frame_d = frame_new;
                        done_d  = 1'b1;
                        state_d = StIdle;
`ifdef DCF77_READER_CHECK_EN
                        frame_ok_d = plausible(frame_new);
`endif
                    end else begin
                        shadow_d = {shadow_q[42:0], wb.wb_data_i};
                        byte_d   = byte_q + 3'd1;
                        state_d  = StGap;
                    end
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StGap: begin
                state_d = StReq;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            byte_q   <= 3'd0;
            tmo_q    <= 8'd0;
            shadow_q <= '0;
            frame_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            byte_q   <= byte_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

`ifdef DCF77_READER_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_ok_q <= 1'b0;
        end else begin
            frame_ok_q <= frame_ok_d;
        end
    end

    assign frame_ok = frame_ok_q;
`endif

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign err       = err_q;
    assign frame     = frame_q;
    assign wb.wb_cyc = (state_q != StIdle);
    assign wb.wb_stb = (state_q == StReq);
    assign wb.wb_we  = 1'b0;

endmodule

// File: tb/tb_dcf77_frame_reader.sv
module tb_dcf77_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, err;
    logic [58:0] frame;
    logic        frame_ok_w;

    dcf77_frame_reader_if wb_if ();

    dcf77_frame_reader #(
        .ACK_TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .frame    (frame),
`ifdef DCF77_READER_CHECK_EN
        .frame_ok (frame_ok_w),
`endif
        .wb       (wb_if)
    );

`ifndef DCF77_READER_CHECK_EN
    assign frame_ok_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- register slave model ----------------
    logic [7:0] sl_bytes [8];
    int         sl_dly   [8];
    bit         sl_mute = 1'b0;
    int         sl_ptr  = 0;
    int         sl_wait = 0;

    always @(posedge clk) begin
        if (rst) begin
            wb_if.wb_ack    <= 1'b0;
            wb_if.wb_data_i <= 8'h00;
            sl_ptr          <= 0;
            sl_wait         <= 0;
        end else if (wb_if.wb_ack) begin
            wb_if.wb_ack <= 1'b0;
            sl_ptr       <= (sl_ptr + 1) % 8;
        end else if (wb_if.wb_stb && !sl_mute) begin
            if (sl_wait < sl_dly[sl_ptr]) begin
                sl_wait <= sl_wait + 1;
            end else begin
                wb_if.wb_ack    <= 1'b1;
                wb_if.wb_data_i <= sl_bytes[sl_ptr];
                sl_wait         <= 0;
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        bit          is_err;
        logic [58:0] frame;
        bit          ok;
        int          cycle;
    } exp_t;

    exp_t        exp_q [$];
    logic [58:0] model_frame = '0;
    bit          model_ok = 1'b0;

    function automatic logic [58:0] ref_frame();
        logic [63:0] acc = '0;
        for (int n = 0; n < 8; n++) acc = acc | (64'(sl_bytes[n]) << (56 - 8 * n));
        return acc[58:0];
    endfunction

    function automatic bit ref_ok(input logic [58:0] f);
        int ones_a = 0, ones_b = 0, ones_c = 0;
        for (int i = 21; i <= 28; i++) ones_a += int'(f[i]);
        for (int i = 29; i <= 35; i++) ones_b += int'(f[i]);
        for (int i = 36; i <= 58; i++) ones_c += int'(f[i]);
        return (f[0] == 1'b0) && (f[20] == 1'b1) && (ones_a % 2 == 0) &&
               (ones_b % 2 == 0) && (ones_c % 2 == 0);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Transaction accepted in cycle k: expectation pushed.
    task automatic push_done(input int k);
        exp_t e;
        int   extra = 0;
        for (int n = 0; n < 8; n++) extra += sl_dly[n];
        e.is_err    = 1'b0;
        e.frame     = ref_frame();
        e.ok        = ref_ok(e.frame);
        e.cycle     = k + 24 + extra;
        model_frame = e.frame;
        model_ok    = e.ok;
        exp_q.push_back(e);
    endtask

    task automatic push_err(input int k, input int off);
        exp_t e;
        e.is_err = 1'b1;
        e.frame  = model_frame;
        e.ok     = model_ok;
        e.cycle  = k + off;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (done || err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: done=%b err=%b with no transaction pending",
                         done, err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("event_kind_err", {63'd0, err}, {63'd0, e.is_err});
                check("event_kind_done", {63'd0, done}, {63'd0, !e.is_err});
                check("event_cycle", 64'(cyc), 64'(e.cycle));
                check("frame", {5'd0, frame}, {5'd0, e.frame});
                check("cyc_stb_busy_at_end", {61'd0, wb_if.wb_cyc, wb_if.wb_stb, busy}, 64'd0);
`ifdef DCF77_READER_CHECK_EN
                check("frame_ok", {63'd0, frame_ok_w}, {63'd0, e.ok});
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_frame = '0;
        model_ok    = 1'b0;
    endtask

    task automatic clear_slave();
        for (int n = 0; n < 8; n++) sl_dly[n] = 0;
        sl_mute = 1'b0;
    endtask

    task automatic set_bytes(input logic [63:0] v);
        for (int n = 0; n < 8; n++) sl_bytes[n] = v[63 - 8 * n -: 8];
    endtask

    task automatic rand_bytes();
        for (int n = 0; n < 8; n++) sl_bytes[n] = 8'($urandom);
    endtask

    task automatic run_tx();
        @(posedge clk);
        #1;
        push_done(cyc);
        pulse_start();
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_slave();
        set_bytes(64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_outputs",
              {58'd0, busy, done, err, wb_if.wb_cyc, wb_if.wb_stb, wb_if.wb_we}, 64'd0);
        check("reset_frame", {5'd0, frame}, 64'd0);
        check("reset_frame_ok", {63'd0, frame_ok_w}, 64'd0);

        // Nominal frame and byte-0 masking.
        set_bytes(64'h05112233_44556670);
        run_tx();
        check("nominal_frame_const", {5'd0, frame}, {5'd0, 59'h5112233_44556670});
        set_bytes(64'hFD000000_00000000);
        run_tx();
        check("byte0_mask_const", {5'd0, frame}, {5'd0, 59'h5000000_00000000});

        // Slave stalls byte 4 by 3 cycles.
        set_bytes(64'h05112233_44556670);
        sl_dly[4] = 3;
        run_tx();
        clear_slave();

        // Plausibility pattern and a single-bit corruption.
        set_bytes(64'h00000000_00100000);
        run_tx();
        set_bytes(64'h00000000_10100000);
        run_tx();

        // Slave never acks: err after 16 stb cycles, frame unchanged.
        sl_mute = 1'b1;
        @(posedge clk);
        #1;
        push_err(cyc, 17);
        pulse_start();
        wait_drain();
        sl_mute = 1'b0;

        // Ack in the very cycle the timeout is reached still counts.
        rand_bytes();
        sl_dly[0] = 14;
        run_tx();
        // One cycle later is a timeout; the slave is left mid-wait, so reset.
        sl_dly[0] = 15;
        @(posedge clk);
        #1;
        push_err(cyc, 17);
        pulse_start();
        wait_drain();
        clear_slave();
        do_reset();

        // Reset during byte 3, then a clean transaction.
        rand_bytes();
        @(posedge clk);
        #1;
        pulse_start();
        begin
            int n = 0;
            while (sl_ptr != 3 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("reached_byte3", 64'(sl_ptr), 64'd3);
        end
        do_reset();
        check("mid_reset_idle", {61'd0, busy, wb_if.wb_cyc, wb_if.wb_stb}, 64'd0);
        check("mid_reset_frame", {5'd0, frame}, 64'd0);
        rand_bytes();
        run_tx();

        // start while busy is ignored.
        rand_bytes();
        @(posedge clk);
        #1;
        push_done(cyc);
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        pulse_start();
        wait_drain();
        repeat (30) @(posedge clk);
        #1;
        check("no_extra_tx_busy", {63'd0, busy}, 64'd0);

        // start in the done cycle begins a new transaction.
        rand_bytes();
        @(posedge clk);
        #1;
        push_done(cyc);
        pulse_start();
        begin
            int n = 0;
            while (!done && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("first_done_seen", {63'd0, done}, 64'd1);
        end
        rand_bytes();
        push_done(cyc);
        pulse_start();
        wait_drain();

        // Randomized transactions with occasional slave stalls.
        for (int t = 0; t < 16; t++) begin
            rand_bytes();
            for (int n = 0; n < 8; n++)
                sl_dly[n] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            run_tx();
        end
        clear_slave();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dcf77_frame_reader.md
DCF77_FRAME_READER -- requirements
Module: dcf77_frame_reader

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: number of consecutive stb-high cycles without wb_ack before a transaction is aborted; SHALL be in the range 2..255.
REQ-002 Port clk, input, 1: single clock; all state SHALL change only on its rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: single-cycle request to fetch one 8-byte frame.
REQ-005 Port busy, output, 1: high while a transaction is in progress.
REQ-006 Port done, output, 1: one-cycle pulse when a frame has been captured successfully.
REQ-007 Port err, output, 1: one-cycle pulse when a transaction aborts on timeout.
REQ-008 Port frame, output, 59: last successfully captured DCF77 frame, bits [58:0].
REQ-009 Port frame_ok, output, 1: plausibility flag for frame; present only with DCF77_READER_CHECK_EN.
REQ-010 Port wb_cyc, output, 1: Wishbone cycle.
REQ-011 Port wb_stb, output, 1: Wishbone strobe.
REQ-012 Port wb_we, output, 1: Wishbone write enable; SHALL be constant 0.
REQ-013 Port wb_ack, input, 1: Wishbone acknowledge from the register slave.
REQ-014 Port wb_data_i, input, 8: Wishbone read data from the slave.

Function
REQ-015 The state machine SHALL have three states: IDLE, REQ and GAP; the state after reset SHALL be IDLE.
REQ-016 In IDLE, start=1 SHALL move the state to REQ with wb_cyc=wb_stb=1 from the next cycle; busy SHALL be high whenever the state is not IDLE.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 In REQ, wb_stb SHALL stay high until wb_ack=1 is sampled; wb_data_i SHALL be captured in that same cycle.
REQ-019 After each ack of bytes 0..6, the state SHALL go to GAP for exactly one cycle with wb_stb=0 and wb_cyc=1, then return to REQ.
REQ-020 Each byte SHALL take 3 cycles with a 1-cycle-latency slave; if start is sampled at edge k, the byte-7 ack SHALL occur in cycle k+23 and done=1 in cycle k+24.
REQ-021 wb_cyc SHALL stay high continuously from the first REQ until the byte-7 ack, or until a timeout.
REQ-022 Byte mapping: byte 0 bits [2:0] SHALL map to frame[58:56], with bits [7:3] discarded; byte n (n=1..7) SHALL map to frame[63-8n:56-8n], so byte 7 maps to frame[7:0].
REQ-023 Bytes SHALL be assembled in a shadow register; frame SHALL update atomically in the cycle done rises.
REQ-024 On the byte-7 ack the state SHALL go to IDLE; wb_cyc and wb_stb SHALL be 0 and busy SHALL be 0 in the cycle done=1.
REQ-025 start=1 in the cycle done=1 SHALL be accepted and SHALL begin a new transaction.
REQ-026 Each REQ state SHALL count stb-high cycles; reaching ACK_TIMEOUT without an ack SHALL drop wb_cyc and wb_stb, pulse err, return to IDLE and leave frame unchanged.
REQ-027 An ack arriving in the same cycle the timeout is reached SHALL count as an ack, with no err.
REQ-028 wb_ack sampled in IDLE or GAP SHALL be ignored.

Reset
REQ-029 On rst=1 at a clock edge: state=IDLE; wb_cyc, wb_stb, wb_we, busy, done and err all 0; frame=0; frame_ok=0; shadow register and counters cleared.
REQ-030 Reset mid-transaction SHALL abort without a done or err pulse; rst SHALL be shared with the slave so both byte pointers restart at byte 0.

Configuration
REQ-031 With DCF77_READER_CHECK_EN defined, frame_ok SHALL be registered alongside frame at done: 1 if and only if frame[0]=0, frame[20]=1, ^frame[28:21]=0, ^frame[35:29]=0 and ^frame[58:36]=0.
REQ-032 Without DCF77_READER_CHECK_EN, the frame_ok port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Verification
REQ-033 Slave bytes 05,11,22,33,44,55,66,70 with start at edge k -> done in cycle k+24 and frame=59'h5112233_44556670.
REQ-034 Byte 0 = FD, other bytes 00 -> frame=59'h5000000_00000000; bits [7:3] of byte 0 are ignored.
REQ-035 Slave delays ack by 3 cycles on byte 4 -> wb_stb held until the ack, transaction extended by 3 cycles, frame still correct.
REQ-036 Slave never acks (ACK_TIMEOUT=16) -> err pulse after 16 stb-high cycles, wb_cyc=0, frame unchanged, done never asserted.
REQ-037 rst asserted during byte 3, then start -> next transaction reads bytes 0..7 correctly; start applied in the done cycle and start applied while busy both checked.
REQ-038 With DCF77_READER_CHECK_EN defined: frame 59'h100000 -> frame_ok=1; the same frame with bit 28 flipped -> frame_ok=0.
